// File: rtl/vga_pkg.sv
// Shared constants and FSM encoding for the VGA mode controller.
package vga_pkg;

    localparam int KEY_W = 10;

    localparam logic [3:0] MODE_BARS  = 4'd8;
    localparam logic [3:0] MODE_BLINK = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    // Index of the lowest set bit; zero when nothing is set.
    function automatic logic [3:0] lowest_set(input logic [KEY_W-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a whole-vector debouncer: any change
// restarts the count, and the vector is accepted once it has held still.
module key_debounce
    import vga_pkg::*;
#(
    parameter int DEB_CYCLES = 250000
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] stable
);

    localparam int            CW      = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [KEY_W-1:0] sync1;
    logic [KEY_W-1:0] sync2;
    logic [KEY_W-1:0] sample_d;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (sync2 != sample_d) begin
            cnt_next = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // The sample is accepted on the same edge the counter reaches its limit.
    always_ff @(posedge ck) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            sample_d <= '0;
            cnt      <= '0;
            stable   <= '0;
        end else begin
            sync1    <= key_in;
            sync2    <= sync1;
            sample_d <= sync2;
            cnt      <= cnt_next;
            if ((sync2 == sample_d) && (cnt_next == CNT_MAX)) begin
                stable <= sync2;
            end
        end
    end

endmodule

// File: rtl/vga_mode_ctrl.sv
// Push-button display-mode selector: debounced presses request a mode that is
// applied only at a frame boundary; pixel colour is generated from the mode.
module vga_mode_ctrl
    import vga_pkg::*;
#(
    parameter int DEB_CYCLES = 250000
) (
    input  logic       ck,
    input  logic       rst,
    input  logic [9:0] key,
    input  logic       hvalid,
    input  logic       vvalid,
    output logic       r,
    output logic       g,
    output logic       b,
    output logic [3:0] mode,
    output logic       pending
);

    logic [KEY_W-1:0] stable;
    logic [KEY_W-1:0] stable_d;
    logic [KEY_W-1:0] press_vec;
    logic             press;
    logic [3:0]       press_idx;

    logic             hv_d;
    logic             vv_d;
    logic             boundary;

    state_t           state;
    state_t           state_next;
    logic [3:0]       req;
    logic [3:0]       req_next;
    logic [3:0]       mode_next;

    logic [9:0]       x;
    logic [9:0]       y;
    logic [5:0]       frame_cnt;
    logic [2:0]       colour;
    logic [2:0]       rgb;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_key_debounce (
        .ck     (ck),
        .rst    (rst),
        .key_in (key),
        .stable (stable)
    );

    assign press_vec = stable & ~stable_d;
    assign press     = |press_vec;
    assign press_idx = lowest_set(press_vec);
    assign boundary  = vv_d & ~vvalid;

    always_ff @(posedge ck) begin
        if (rst) begin
            stable_d <= '0;
            hv_d     <= 1'b0;
            vv_d     <= 1'b0;
        end else begin
            stable_d <= stable;
            hv_d     <= hvalid;
            vv_d     <= vvalid;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state <= ST_IDLE;
            req   <= '0;
            mode  <= '0;
        end else begin
            state <= state_next;
            req   <= req_next;
            mode  <= mode_next;
        end
    end

    // A press on the boundary cycle while idle only arms the request, so the
    // frame that is starting keeps one mode from its first pixel.
    always_comb begin
        state_next = state;
        req_next   = req;
        mode_next  = mode;
        case (state)
            ST_IDLE: begin
                if (press) begin
                    state_next = ST_PEND;
                    req_next   = press_idx;
                end
            end
            ST_PEND: begin
                if (boundary) begin
                    mode_next  = press ? press_idx : req;
                    state_next = ST_IDLE;
                end else if (press) begin
                    req_next = press_idx;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign pending = (state == ST_PEND);

    always_ff @(posedge ck) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
        end else begin
            x <= hvalid ? x + 10'd1 : 10'd0;
            if (!vvalid) begin
                y <= '0;
            end else if (hv_d && !hvalid) begin
                y <= y + 10'd1;
            end
            if (boundary) begin
                frame_cnt <= frame_cnt + 6'd1;
            end
        end
    end

    always_comb begin
        colour = mode[2:0];
        case (mode)
            MODE_BARS:  colour = x[6:4];
            MODE_BLINK: colour = frame_cnt[5] ? 3'b000 : 3'b111;
            default:    colour = mode[2:0];
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            rgb <= '0;
        end else if (hvalid && vvalid) begin
            rgb <= colour;
        end else begin
            rgb <= '0;
        end
    end

    assign r = rgb[2];
    assign g = rgb[1];
    assign b = rgb[0];

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for vga_mode_ctrl with a short debounce window.
`timescale 1ns/1ps
module tb_vga_mode_ctrl;

    localparam int DEB = 8;

    logic       ck;
    logic       rst;
    logic [9:0] key;
    logic       hvalid;
    logic       vvalid;
    logic       r;
    logic       g;
    logic       b;
    logic [3:0] mode;
    logic       pending;

    int n_tests = 0;
    int n_fail  = 0;
    int fcount  = 0;

    logic [2:0] exp_q[$];

    typedef struct {
        logic [9:0] key;
        logic [3:0] exp_mode;
        logic [2:0] exp_rgb;
    } vec_t;

    vec_t vecs[6];

    vga_mode_ctrl #(
        .DEB_CYCLES(DEB)
    ) dut (
        .ck      (ck),
        .rst     (rst),
        .key     (key),
        .hvalid  (hvalid),
        .vvalid  (vvalid),
        .r       (r),
        .g       (g),
        .b       (b),
        .mode    (mode),
        .pending (pending)
    );

    // clock / watchdog
    initial begin
        ck = 1'b0;
        forever #10 ck = ~ck;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic vv_fall();
        vvalid = 1'b0;
        hvalid = 1'b0;
        tick(1);
        fcount = (fcount + 1) % 64;
    endtask

    task automatic frame();
        vvalid = 1'b1;
        tick(2);
        vv_fall();
    endtask

    task automatic press(input logic [9:0] k);
        key = k;
        tick(14);
        key = '0;
        tick(12);
    endtask

    task automatic show_pixel(input string name, input int exp);
        vvalid = 1'b1;
        hvalid = 1'b1;
        tick(1);
        check(name, int'({r, g, b}), exp);
        hvalid = 1'b0;
        tick(1);
        check({name, "_hblank"}, int'({r, g, b}), 0);
        vv_fall();
    endtask

    initial begin
        vecs[0] = '{key: 10'h040, exp_mode: 4'd6, exp_rgb: 3'b110};
        vecs[1] = '{key: 10'h002, exp_mode: 4'd1, exp_rgb: 3'b001};
        vecs[2] = '{key: 10'h080, exp_mode: 4'd7, exp_rgb: 3'b111};
        vecs[3] = '{key: 10'b0000100100, exp_mode: 4'd2, exp_rgb: 3'b010};
        vecs[4] = '{key: 10'h010, exp_mode: 4'd4, exp_rgb: 3'b100};
        vecs[5] = '{key: 10'h3FF, exp_mode: 4'd0, exp_rgb: 3'b000};

        // reset with every key held and the active area asserted
        rst    = 1'b1;
        key    = 10'h3FF;
        hvalid = 1'b1;
        vvalid = 1'b1;
        tick(5);
        check("reset_mode", int'(mode), 0);
        check("reset_pending", int'(pending), 0);
        check("reset_rgb", int'({r, g, b}), 0);
        rst    = 1'b0;
        hvalid = 1'b0;
        vvalid = 1'b0;
        fcount = 0;
        tick(10);
        check("held_key_early", int'(pending), 0);
        tick(1);
        check("held_key_press", int'(pending), 1);
        frame();
        check("held_key_mode", int'(mode), 0);
        check("held_key_clear", int'(pending), 0);
        key = '0;
        tick(12);

        // bouncing key[3], then a clean hold
        for (int c = 0; c < 30; c++) begin
            if (c % 3 == 0) key[3] = ~key[3];
            tick(1);
        end
        check("bounce_no_press", int'(pending), 0);
        key[3] = 1'b1;
        tick(10);
        check("bounce_early", int'(pending), 0);
        tick(1);
        check("bounce_rise", int'(pending), 1);
        key = '0;
        tick(12);
        frame();
        check("bounce_mode", int'(mode), 3);
        check("bounce_pend_clr", int'(pending), 0);
        show_pixel("bounce_rgb", 3);

        // table-driven mode selection
        for (int i = 0; i < 6; i++) begin
            press(vecs[i].key);
            check($sformatf("vec%0d_pending", i), int'(pending), 1);
            frame();
            check($sformatf("vec%0d_mode", i), int'(mode), int'(vecs[i].exp_mode));
            check($sformatf("vec%0d_pend_clr", i), int'(pending), 0);
            show_pixel($sformatf("vec%0d_rgb", i), int'(vecs[i].exp_rgb));
        end

        // overwrite: key[1] then key[5] before the boundary
        press(10'h002);
        check("ovr_pend1", int'(pending), 1);
        press(10'h020);
        check("ovr_pend5", int'(pending), 1);
        vvalid = 1'b1;
        tick(2);
        check("ovr_before", int'(mode), 0);
        vv_fall();
        check("ovr_mode", int'(mode), 5);
        check("ovr_pend_clr", int'(pending), 0);

        // press detected on the boundary cycle while idle
        key    = 10'h040;
        vvalid = 1'b1;
        tick(10);
        vvalid = 1'b0;
        tick(1);
        fcount = (fcount + 1) % 64;
        check("coin_mode_hold", int'(mode), 5);
        check("coin_pending", int'(pending), 1);
        key = '0;
        tick(12);
        frame();
        check("coin_mode", int'(mode), 6);
        check("coin_pend_clr", int'(pending), 0);

        // same-cycle press beats the latched request at the boundary
        press(10'h010);
        check("prec_pending", int'(pending), 1);
        key    = 10'h080;
        vvalid = 1'b1;
        tick(10);
        vvalid = 1'b0;
        tick(1);
        fcount = (fcount + 1) % 64;
        check("prec_mode", int'(mode), 7);
        check("prec_pend_clr", int'(pending), 0);
        key = '0;
        tick(12);
        check("prec_release", int'(pending), 0);

        // vertical bars
        press(10'h100);
        frame();
        check("bars_mode", int'(mode), 8);
        for (int p = 0; p < 140; p++) exp_q.push_back(3'((p >> 4) & 7));
        vvalid = 1'b1;
        hvalid = 1'b1;
        for (int p = 0; p < 140; p++) begin
            logic [2:0] e;
            tick(1);
            e = exp_q.pop_front();
            check($sformatf("bars_px%0d", p), int'({r, g, b}), int'(e));
        end
        hvalid = 1'b0;
        tick(1);
        check("bars_hblank", int'({r, g, b}), 0);
        hvalid = 1'b1;
        tick(1);
        check("bars_x_clear", int'({r, g, b}), 0);
        tick(16);
        check("bars_x16", int'({r, g, b}), 1);
        vvalid = 1'b0;
        tick(1);
        fcount = (fcount + 1) % 64;
        check("bars_vblank", int'({r, g, b}), 0);
        hvalid = 1'b0;

        // blink across the half-period and the counter wrap
        press(10'h200);
        frame();
        check("blink_mode", int'(mode), 9);
        for (int f = 0; f < 70; f++) begin
            vvalid = 1'b1;
            hvalid = 1'b1;
            tick(1);
            check($sformatf("blink_f%0d", fcount), int'({r, g, b}), (fcount < 32) ? 7 : 0);
            vv_fall();
        end

        // reset while a request is pending
        press(10'h008);
        check("mid_pending", int'(pending), 1);
        rst    = 1'b1;
        hvalid = 1'b1;
        vvalid = 1'b1;
        tick(2);
        check("mid_rst_mode", int'(mode), 0);
        check("mid_rst_pending", int'(pending), 0);
        check("mid_rst_rgb", int'({r, g, b}), 0);
        rst    = 1'b0;
        hvalid = 1'b0;
        vvalid = 1'b0;
        fcount = 0;
        tick(1);
        frame();
        check("mid_after_mode", int'(mode), 0);
        check("mid_after_pending", int'(pending), 0);
        show_pixel("mid_after_rgb", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_mode_ctrl.md
VGA_MODE_CTRL -- requirements
Module: vga_mode_ctrl

Interface
REQ-001 SHALL have parameter: DEB_CYCLES, 250000, consecutive stable cycles before a key change is accepted.
REQ-002 SHALL have port: ck  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: key  input  10  raw asynchronous push-button inputs, 1 = pressed.
REQ-005 SHALL have port: hvalid  input  1  horizontal active-area flag from the timing generator.
REQ-006 SHALL have port: vvalid  input  1  vertical active-area flag from the timing generator.
REQ-007 SHALL have port: r, g, b  output  1 each  registered pixel colour.
REQ-008 SHALL have port: mode  output  4  currently applied display mode, 0..9.
REQ-009 SHALL have port: pending  output  1  high while a requested mode awaits a frame boundary.

Function
REQ-010 SHALL pass key through a 2-flop synchronizer before any other use.
REQ-011 SHALL debounce the whole 10-bit vector: a counter clears whenever the synchronized key differs from the previous sample; when the counter reaches DEB_CYCLES-1 with no change, stable_key SHALL load the sample; the counter saturates.
REQ-012 SHALL detect presses as 0->1 bits of stable_key; on a multi-bit press the lowest index wins; the winning index is the requested mode.
REQ-013 SHALL define frame boundary as the cycle after vvalid falls (1 then 0).
REQ-014 SHALL implement FSM states IDLE and PEND; IDLE + press -> PEND, latching the request; PEND + press -> PEND, overwriting the latched request.
REQ-015 SHALL, in PEND at a frame boundary, load mode from the latched request (or from a same-cycle press, which takes precedence) and return to IDLE.
REQ-016 SHALL, on a press coinciding with a boundary in IDLE, enter PEND and apply the press at the next boundary.
REQ-017 SHALL drive pending = 1 exactly in PEND.
REQ-018 SHALL keep a 10-bit x counter: increments each hvalid cycle, clears when hvalid = 0, wraps at 1023.
REQ-019 SHALL keep a 10-bit y counter: increments on each hvalid falling edge, clears when vvalid = 0.
REQ-020 SHALL keep a 6-bit frame counter: increments at each frame boundary and wraps 63 -> 0.
REQ-021 SHALL generate colour by mode: 0-7 give {r,g,b} = mode[2:0]; 8 gives {r,g,b} = x[6:4] (vertical bars); 9 gives all 1 when frame_cnt[5] = 0, else all 0.
REQ-022 SHALL register r, g, b with one-cycle latency from hvalid/vvalid and force them to 0 when the sampled hvalid & vvalid = 0.
REQ-023 SHALL change mode only at a frame boundary, so no frame shows mixed modes.

Reset
REQ-024 SHALL, while rst = 1 at a ck edge, clear the synchronizer, debounce counter, stable_key, FSM (to IDLE), latched request, x, y and frame_cnt, and drive mode = 0, pending = 0 and r = g = b = 0.
REQ-025 SHALL discard any key press or pending request on a reset asserted mid-operation; after release a key already held SHALL register a new press only once it is debounced as 1.

Structure
REQ-026 SHALL place KEY_W = 10, the mode constants (MODE_BARS = 8, MODE_BLINK = 9) and the FSM state encoding in shared package vga_pkg.
REQ-027 SHALL implement the synchronizer and debouncer as sub-module key_debounce (ck, rst, key_in[9:0] -> stable[9:0]), parameterized by DEB_CYCLES.

Verification (DEB_CYCLES = 8, 20 ns clock)
REQ-028 Reset: rst = 1 for 5 cycles with key = 10'h3FF -> mode = 0, pending = 0, rgb = 0 during reset; no press is recognized until key has been stable for 8 cycles after release.
REQ-029 Bounce: key[3] toggles every 3 cycles for 30 cycles, then is held at 1 -> pending rises exactly 2 (synchronizer) + 8 (debounce) + 1 cycles after the hold starts; mode = 3 after the next vvalid fall; rgb = 3'b011 in the active area.
REQ-030 Overwrite: press key[1], then press key[5] before the frame boundary -> mode goes 0 -> 5 directly at one boundary; pending returns to 0 on the same cycle.
REQ-031 Priority/coincidence: key = 10'b0000100100 rises in one cycle -> mode 2; a press whose detection lands on the boundary cycle in IDLE -> applied one frame later.
REQ-032 Patterns: key[9] -> r, g and b are all 1 for frames 0-31 and all 0 for frames 32-63; key[8] -> rgb = x[6:4] and the value steps every 16 pixels; rgb = 0 whenever hvalid or vvalid was 0 one cycle earlier.
